// File: rtl/add_sched_pkg.sv
// Shared defaults and helpers for the add_sched requester/adder scheduler.
package add_sched_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADD_LAT    = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sched_if.sv
// Requester and response channels of add_sched bundled as one interface.
interface add_sched_if
  import add_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/add_rsp_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero when empty.
module add_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  assign pop_ok = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one external adder among NUM_REQ requesters,
// with credit-based issue so the in-order result FIFO can never overflow.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADD_LAT    = DEF_ADD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  add_sched_if.slave        bus,
  output logic [DATA_W-1:0] add_a_o,
  output logic [DATA_W-1:0] add_b_o,
  input  logic [DATA_W-1:0] add_x_i,
  output logic              busy_o
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]        rr_q, rr_d;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any, credit_ok, xfer;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DATA_W-1:0]      add_a_q, add_b_q;
  logic [ADD_LAT-1:0]     pv_q;
  logic [ID_W-1:0]        pid_q [ADD_LAT];
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_valid, fifo_pop;
  logic [ID_W+DATA_W-1:0] fifo_head;

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // A result popped this cycle is not credited back until the next cycle.
  always_comb begin
    int outstanding;
    outstanding = int'(fifo_count);
    for (int k = 0; k < ADD_LAT; k++) outstanding += int'(pv_q[k]);
    credit_ok = (outstanding < FIFO_DEPTH);
  end

  assign xfer = grant_any && credit_ok && rst_n;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = xfer && (grant_idx == ID_W'(gi));
  end
  assign bus.req_ready = req_ready;

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      pv_q    <= '0;
      for (int k = 0; k < ADD_LAT; k++) pid_q[k] <= '0;
    end else begin
      rr_q <= rr_d;
      if (xfer) begin
        add_a_q <= bus.req_a[int'(grant_idx) * DATA_W +: DATA_W];
        add_b_q <= bus.req_b[int'(grant_idx) * DATA_W +: DATA_W];
      end
      for (int k = ADD_LAT - 1; k > 0; k--) begin
        pv_q[k]  <= pv_q[k-1];
        pid_q[k] <= pid_q[k-1];
      end
      pv_q[0]  <= xfer;
      pid_q[0] <= grant_idx;
    end
  end

  assign add_a_o = add_a_q;
  assign add_b_o = add_b_q;

  add_rsp_fifo #(
    .WIDTH (ID_W + DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pv_q[ADD_LAT-1]),
    .push_data_i ({pid_q[ADD_LAT-1], add_x_i}),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign fifo_pop      = fifo_valid && bus.rsp_ready;
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_data  = fifo_head[DATA_W-1:0];
  assign bus.rsp_id    = fifo_head[DATA_W +: ID_W];
  assign busy_o        = (|pv_q) || fifo_valid;

endmodule

// File: tb/tb_add_sched.sv
// Randomized bench for add_sched with a queue-based reference model and
// directed scenarios pinned by literal expectations.
module tb_add_sched;
  import add_sched_pkg::*;

  localparam int N     = DEF_NUM_REQ;
  localparam int W     = DEF_DATA_W;
  localparam int LAT   = DEF_ADD_LAT;
  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_sched_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  logic [W-1:0] add_a, add_b, add_x;
  logic         busy;

  // Shared adder: combinational, matching a one-cycle adder latency.
  assign add_x = add_a + add_b;

  add_sched #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .ADD_LAT    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .add_a_o (add_a),
    .add_b_o (add_b),
    .add_x_i (add_x),
    .busy_o  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct {
    int id;
    int data;
    int t;
  } ent_t;

  ent_t pipe_q[$];
  ent_t fifo_q[$];
  int   rr     = 0;
  int   cyc    = 0;
  int   last_a = 0;
  int   last_b = 0;

  int xfer_id[$], xfer_cyc[$];
  int rsp_d[$], rsp_i[$], rsp_c[$];
  int max_cnt = 0;

  task automatic clear_logs();
    xfer_id.delete(); xfer_cyc.delete();
    rsp_d.delete(); rsp_i.delete(); rsp_c.delete();
  endtask

  // Reference model: queues of issued ops and buffered results.
  initial begin : compare
    int   g, ga, gb;
    bit   pop;
    ent_t e;
    logic [N-1:0] exp_ready;
    forever begin
      @(negedge clk);
      g = -1; ga = 0; gb = 0; pop = 1'b0;
      if (!rst_n) begin
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data",  int'(bus.rsp_data), 0);
        chk("rst_rsp_id",    int'(bus.rsp_id), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_add_a",     int'(add_a), 0);
        chk("rst_add_b",     int'(add_b), 0);
      end else begin
        exp_ready = '0;
        if (pipe_q.size() + fifo_q.size() < DEPTH)
          for (int k = 0; k < N; k++)
            if (g < 0 && bus.req_valid[(rr + k) % N]) g = (rr + k) % N;
        if (g >= 0) begin
          exp_ready[g] = 1'b1;
          ga = int'(bus.req_a[g*W +: W]);
          gb = int'(bus.req_b[g*W +: W]);
        end
        chk("req_ready", int'(bus.req_ready), int'(exp_ready));
        chk("rsp_valid", int'(bus.rsp_valid), int'(fifo_q.size() > 0));
        if (fifo_q.size() > 0) begin
          chk("rsp_data", int'(bus.rsp_data), fifo_q[0].data);
          chk("rsp_id",   int'(bus.rsp_id),   fifo_q[0].id);
        end
        chk("busy",  int'(busy),  int'(pipe_q.size() + fifo_q.size() > 0));
        chk("add_a", int'(add_a), last_a);
        chk("add_b", int'(add_b), last_b);
        pop = (fifo_q.size() > 0) && bus.rsp_ready;
        for (int k = 0; k < N; k++)
          if (bus.req_ready[k]) begin
            xfer_id.push_back(k);
            xfer_cyc.push_back(cyc);
          end
        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_d.push_back(int'(bus.rsp_data));
          rsp_i.push_back(int'(bus.rsp_id));
          rsp_c.push_back(cyc);
          $display("rsp id=%0d data=0x%02h cyc=%0d", bus.rsp_id, bus.rsp_data, cyc);
        end
        if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pipe_q.delete(); fifo_q.delete();
        rr = 0; last_a = 0; last_b = 0;
      end else begin
        if (pop) void'(fifo_q.pop_front());
        while (pipe_q.size() > 0 && cyc - pipe_q[0].t >= LAT)
          fifo_q.push_back(pipe_q.pop_front());
        if (g >= 0) begin
          e.id = g; e.data = (ga + gb) % (1 << W); e.t = cyc;
          pipe_q.push_back(e);
          last_a = ga; last_b = gb;
          rr = (g + 1) % N;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
  endtask

  initial begin : stim
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Single op on requester 2
    clear_logs();
    bus.rsp_ready = 1'b1;
    set_op(2, 8'h12, 8'h34);
    bus.req_valid = 4'b0100;
    step(1);
    bus.req_valid = '0;
    step(4);
    chk("single_grant", at(xfer_id, 0), 2);
    chk("single_data",  at(rsp_d, 0), 'h46);
    chk("single_id",    at(rsp_i, 0), 2);
    chk("single_lat",   at(rsp_c, 0) - at(xfer_cyc, 0), LAT + 1);

    // Carry discarded, requester 3 (round-robin pointer then returns to 0)
    clear_logs();
    set_op(3, 8'hF0, 8'h20);
    bus.req_valid = 4'b1000;
    step(1);
    bus.req_valid = '0;
    step(4);
    chk("wrap_data", at(rsp_d, 0), 'h10);
    chk("wrap_id",   at(rsp_i, 0), 3);

    // Fairness with all requesters valid
    clear_logs();
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step(1);
    end
    bus.req_valid = '0;
    step(6);
    chk("fair_count", xfer_id.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("fair_grant", at(xfer_id, k), k % 4);
      chk("fair_rsp_id", at(rsp_i, k), k % 4);
    end

    // Backpressure: credit stops issue at FIFO_DEPTH outstanding
    clear_logs();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step(1);
    end
    chk("bp_xfers", xfer_id.size(), 4);
    chk("bp_ready_low", int'(bus.req_ready), 0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      step(1);
    end
    for (int k = 0; k < 4; k++) chk("bp_rsp_id", at(rsp_i, k), k);
    chk("bp_resume", int'(xfer_id.size() > 4), 1);
    bus.req_valid = '0;
    step(8);

    // Reset with three results outstanding
    clear_logs();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step(1);
    end
    bus.req_valid = '0;
    step(1);
    chk("mid_xfers", xfer_id.size(), 3);
    chk("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", int'(bus.rsp_valid), 0);
    chk("mid_busy", int'(busy), 0);
    step(2);
    rst_n = 1'b1;
    clear_logs();
    bus.rsp_ready = 1'b1;
    step(8);
    chk("mid_stale", rsp_d.size(), 0);

    // Streaming: one op in and one result out per cycle
    clear_logs();
    max_cnt = 0;
    bus.req_valid = '1;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      step(1);
    end
    bus.req_valid = '0;
    step(5);
    chk("stream_xfers", xfer_id.size(), 20);
    chk("stream_rsps", rsp_d.size(), 20);
    chk("stream_lat", at(rsp_c, 0) - at(xfer_cyc, 0), LAT + 1);
    for (int k = 1; k < 20; k++) chk("stream_gap", at(rsp_c, k) - at(rsp_c, k - 1), 1);
    chk("stream_fifo_le1", int'(max_cnt <= 1), 1);

    // Random traffic, including long stalls and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_ops();
      bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
      if (i < 2000) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      else          bus.rsp_ready = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step(10);
    chk("final_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 4, number of requesters; DATA_W, 8, operand/result width; ADD_LAT, 1, adder latency in cycles (>=1); FIFO_DEPTH, 4, result FIFO entries (power of 2).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  NUM_REQ  per-requester operand-pair valid.
REQ-005 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-006 req_a, req_b  in  NUM_REQ*DATA_W  packed operands; requester i at bits [i*DATA_W +: DATA_W].
REQ-007 add_a, add_b  out  DATA_W  registered operands to the shared Add datapath.
REQ-008 add_x  in  DATA_W  Add datapath result, valid ADD_LAT cycles after add_a/add_b update.
REQ-009 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  DATA_W; rsp_id  out  clog2(NUM_REQ)  result channel.
REQ-010 busy  out  1  high while any operation is in the pipeline or FIFO.

Function
REQ-011 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i] at a rising edge.
REQ-012 Arbitration SHALL be round-robin: search starts at rr_ptr; the first valid requester gets req_ready; after a transfer rr_ptr = granted+1 mod NUM_REQ; with no transfer rr_ptr holds.
REQ-013 Credit: outstanding = pipeline occupancy + FIFO count; all req_ready SHALL be low when outstanding >= FIFO_DEPTH (a same-cycle pop is not credited).
REQ-014 On a transfer at edge T, add_a/add_b SHALL take req_a[i]/req_b[i] at edge T; they hold last value when idle.
REQ-015 A valid/id shift pipeline of depth ADD_LAT SHALL track each issue; at its output add_x and id SHALL be pushed into the FIFO, first result at edge T+ADD_LAT.
REQ-016 Result SHALL be add_x as delivered; the block performs no arithmetic (expected sum is (a+b) mod 2^DATA_W, carry discarded).
REQ-017 rsp_valid = FIFO not empty; rsp_data/rsp_id = head entry; pop on rsp_valid && rsp_ready.
REQ-018 Simultaneous push and pop SHALL both occur, count unchanged; FIFO SHALL never overflow (guaranteed by REQ-013); pop on empty impossible.
REQ-019 Results SHALL leave in issue order, one per cycle maximum; peak throughput one op per cycle with rsp_ready held high.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH with count in 0..FIFO_DEPTH.
REQ-021 rsp_ready low indefinitely SHALL stall issue only via credit; pipeline contents are never dropped.

Reset
REQ-022 On reset low: req_ready=0, add_a=0, add_b=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, rr_ptr=0, pipeline valids and FIFO cleared.
REQ-023 Reset mid-operation SHALL discard all in-flight and buffered results; no response for them after release.
REQ-024 First transfer SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-025 Shared package SHALL hold default DATA_W, NUM_REQ, ADD_LAT, FIFO_DEPTH and the id-width function.
REQ-026 Result FIFO SHALL be a sub-module add_rsp_fifo (sync, width DATA_W+id width, depth FIFO_DEPTH, count output).
REQ-027 The Add datapath SHALL be instantiated outside; the bench connects it between add_a/add_b and add_x.

Verification
REQ-028 Single op: req 2 valid a=0x12 b=0x34, rsp_ready=1 -> rsp_data=0x46, rsp_id=2, ADD_LAT+1 cycles after transfer.
REQ-029 Wrap: a=0xF0 b=0x20 -> rsp_data=0x10.
REQ-030 Fairness: all 4 valid continuously for 8 transfers -> grant order 0,1,2,3,0,1,2,3; rsp_id in same order.
REQ-031 Backpressure: rsp_ready=0, all valid -> exactly 4 transfers then req_ready all 0; rsp_ready=1 -> 4 results in order, then issue resumes.
REQ-032 Reset mid-run: assert reset with 3 ops outstanding -> rsp_valid=0, busy=0 immediately; no stale results after release.
REQ-033 Concurrent push/pop: streaming 20 ops with rsp_ready=1 -> one result per cycle, FIFO count never exceeds 1.
